// File: rtl/rx_fifo_pop_ctrl.sv
// Read-side pop controller behind the rx CDC FIFO: primes, pops into a 2-entry buffer, streams out.
// Optional RX_POP_FLUSH_ON_DISSYNC_EN: a dissync pulse in RUN flushes the buffer and re-primes.
module rx_fifo_pop_ctrl #(
   parameter int WR_WIDTH      = 48,
   parameter int START_THRESH  = 4,
   parameter int DISSYNC_CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_enable,
   input  logic                     canpop,
   input  logic [WR_WIDTH-1:0]      data_rd,
   input  logic                     dissync,
   output logic                     pop_rd,
   output logic [WR_WIDTH-1:0]      out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     running,
   output logic [DISSYNC_CNT_W-1:0] dissync_count,
   output logic                     dissync_sticky,
   input  logic                     clr_stats,
   output logic [1:0]               dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic [3:0] LP_PRIME_LAST = 4'(START_THRESH - 1);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [3:0]                 r_prime_cnt;
   logic [3:0]                 w_prime_cnt_nxt;
   logic [WR_WIDTH-1:0]        r_head;
   logic [WR_WIDTH-1:0]        r_tail;
   logic [1:0]                 r_occ;
   logic [DISSYNC_CNT_W-1:0]   r_ds_cnt;
   logic                       r_ds_sticky;
   logic                       w_flush;
   logic                       w_push;
   logic                       w_consume;
   logic                       w_ds;

`ifdef RX_POP_FLUSH_ON_DISSYNC_EN
   assign w_flush = in_enable & dissync & (r_state == ST_RUN);
`else
   assign w_flush = 1'b0;
`endif

   // Stream handshake: a word transfers on every edge where out_valid & out_ready
   // (and the block is enabled); out_data/out_valid never change while stalled.
   assign w_ds      = in_enable & dissync;
   assign out_valid = (r_occ != 2'd0);
   assign w_consume = in_enable & out_valid & out_ready;
   assign w_push    = ~reset & in_enable & (r_state == ST_RUN) & canpop
                      & (r_occ != 2'd2) & ~w_flush;
   assign pop_rd    = w_push;

   assign out_data       = r_head;
   assign running        = (r_state == ST_RUN);
   assign dissync_count  = r_ds_cnt;
   assign dissync_sticky = r_ds_sticky;
   assign dbg_state      = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_prime_cnt <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_prime_cnt <= w_prime_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_prime_cnt_nxt = r_prime_cnt;
      if (in_enable) begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt     = ST_PRIME;
               w_prime_cnt_nxt = 4'd0;
            end
            ST_PRIME: begin
               // Only an unbroken run of canpop cycles counts towards starting.
               if (!canpop) begin
                  w_prime_cnt_nxt = 4'd0;
               end else if (r_prime_cnt == LP_PRIME_LAST) begin
                  w_state_nxt     = ST_RUN;
                  w_prime_cnt_nxt = 4'd0;
               end else begin
                  w_prime_cnt_nxt = r_prime_cnt + 4'd1;
               end
            end
            ST_RUN: begin
               if (w_flush) begin
                  w_state_nxt     = ST_PRIME;
                  w_prime_cnt_nxt = 4'd0;
               end
            end
            default: begin
               w_state_nxt     = ST_IDLE;
               w_prime_cnt_nxt = 4'd0;
            end
         endcase
      end
   end

   // Head always holds the oldest word; tail is only used when two are held.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= 2'd0;
      end else if (w_flush) begin
         r_occ <= 2'd0;
      end else begin
         if (w_push && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_consume))) begin
            r_head <= data_rd;
         end else if (w_consume && (r_occ == 2'd2)) begin
            r_head <= r_tail;
         end
         if (w_push && (r_occ == 2'd1) && !w_consume) begin
            r_tail <= data_rd;
         end
         case ({w_push, w_consume})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // clr_stats is honoured even while frozen; a coincident dissync survives the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ds_cnt    <= '0;
         r_ds_sticky <= 1'b0;
      end else if (clr_stats) begin
         r_ds_cnt    <= DISSYNC_CNT_W'(w_ds);
         r_ds_sticky <= w_ds;
      end else if (w_ds) begin
         if (r_ds_cnt != '1) begin
            r_ds_cnt <= r_ds_cnt + 1'b1;
         end
         r_ds_sticky <= 1'b1;
      end
   end

endmodule
